booth_multiplier_32bit: RTL



---
 rtl/booth_multiplier_32bit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/booth_multiplier_32bit.sv
// booth_multiplier_32bit
// Sequential radix-2 Booth multiplier: two 32-bit two's-complement operands,
// one Booth step per clock, signed 64-bit product after 32 iterations.
// Handshake: start is accepted in IDLE or DONE, busy covers the iterations,
// done pulses for one cycle when product becomes valid.
// Optional feature: define MUL_OVF_FLAG_EN to add the registered ovf output,
// set when the product does not fit in a 32-bit signed value.

module booth_multiplier_32bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
`ifdef MUL_OVF_FLAG_EN
  ,
  output logic        ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state;

  // 33-bit accumulator and multiplicand so that M = -2^31 never overflows
  logic [32:0] m;
  logic [32:0] acc;
  logic [31:0] q;
  logic        qm1;
  logic [4:0]  count;

  logic [32:0] sum;
  logic [32:0] acc_next;
  logic [31:0] q_next;
  logic        qm1_next;
  logic [63:0] product_next;
  logic        ovf_next;

  // One Booth step: add/subtract M per {Q[0],q_-1}, then arithmetic right shift
  always_comb begin
    sum = acc;
    case ({q[0], qm1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    acc_next     = {sum[32], sum[32:1]};
    q_next       = {sum[0], q[31:1]};
    qm1_next     = q[0];
    product_next = {acc_next[31:0], q_next};
    ovf_next     = !((product_next[63:31] == 33'd0) ||
                     (product_next[63:31] == {33{1'b1}}));
  end

  // Control FSM and datapath registers; outputs are registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= 64'd0;
      m       <= 33'd0;
      acc     <= 33'd0;
      q       <= 32'd0;
      qm1     <= 1'b0;
      count   <= 5'd0;
`ifdef MUL_OVF_FLAG_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            m     <= {a[31], a};
            q     <= b;
            acc   <= 33'd0;
            qm1   <= 1'b0;
            count <= 5'd0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_next;
          q     <= q_next;
          qm1   <= qm1_next;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= product_next;
`ifdef MUL_OVF_FLAG_EN
            ovf     <= ovf_next;
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifndef MUL_OVF_FLAG_EN
  // Overflow detection is computed but has no consumer in this build
  logic unused_ovf;
  assign unused_ovf = ovf_next;
`endif

endmodule
